// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for the whole CYC.
// Optional forced termination of hung slave cycles is built when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_2m #(
   parameter int ADDR_WIDTH     = 21,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   output logic                  m0_ack_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   output logic                  m1_ack_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_addr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   input  logic                  s_ack_i,
   output logic [1:0]            gnt_o,
   output logic                  timeout_o
);

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   to_fire;

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [15:0]           TO_LIMIT = 16'(TIMEOUT_CYCLES);
   localparam logic [DATA_WIDTH-1:0] TO_DATA  = DATA_WIDTH'(32'hDEAD_BEEF);

   logic [15:0] cnt_q, cnt_d;

   assign to_fire   = (state_q != IDLE) && (cnt_q == TO_LIMIT);
   assign timeout_o = to_fire;

   // Counts stalled strobe cycles; restarts on every grant change and every slave ACK.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE || state_d != state_q || s_ack_i) begin
         cnt_d = '0;
      end else if (s_stb_o && cnt_q != TO_LIMIT) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign to_fire            = 1'b0;
   assign timeout_o          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_d = GNT0;
            end else if (m1_cyc_i) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            if (to_fire) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end else if (!m0_cyc_i) begin
               last_d  = 1'b0;
               state_d = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (to_fire) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end else if (!m1_cyc_i) begin
               last_d  = 1'b1;
               state_d = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign gnt_o = state_q;

   // Unregistered mux: slave latency reaches the masters unchanged.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_dat_o  = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      case (state_q)
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_dat_o = s_dat_i;
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_dat_o = s_dat_i;
         end
         default: ;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      if (to_fire) begin
         s_cyc_o = 1'b0;
         s_stb_o = 1'b0;
         if (state_q == GNT0) begin
            m0_ack_o = 1'b1;
            m0_dat_o = TO_DATA;
         end else begin
            m1_ack_o = 1'b1;
            m1_dat_o = TO_DATA;
         end
      end
`endif
   end

endmodule
